mul_hilo_ctrl: RTL and testbench

//  Sequencer for the CPU multiply unit. Accepts MULT/MULTU requests and converts signed operands to magnitudes.

---
 rtl/mul_pkg.sv | 24 ++
 rtl/mul_core_u.sv | 81 ++++++++
 rtl/mul_hilo_ctrl.sv | 123 ++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiply/HI-LO sequencer and its multiplier core.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_LAT   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_e;

  // Unsigned magnitude of an operand. The most negative value maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [MUL_WIDTH-1:0] mul_mag(input logic [MUL_WIDTH-1:0] x,
                                                   input logic                 is_signed);
    return (is_signed && x[MUL_WIDTH-1]) ? -x : x;
  endfunction

  // Two's complement negation of a full-width product.
  function automatic logic [2*MUL_WIDTH-1:0] mul_neg(input logic [2*MUL_WIDTH-1:0] p);
    return -p;
  endfunction

endpackage

// File: rtl/mul_core_u.sv
// Fixed-latency unsigned WIDTH x WIDTH multiplier. Stage 1 registers the shifted
// partial products; the adder-tree sum is registered next, and any further
// latency is plain delay stages. No handshake: the caller tracks validity.
module mul_core_u #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] pp_d [WIDTH];

  // Shifted partial products, one per multiplier bit.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp_d[i] = b[i] ? (PW'(a) << i) : '0;
    end
  end

  if (LAT == 1) begin : g_lat1
    logic [PW-1:0] sum;
    logic [PW-1:0] p_q;

    // Single stage: sum the partial products directly.
    always_comb begin
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
        sum = sum + pp_d[i];
      end
    end

    // Product register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) p_q <= '0;
      else        p_q <= sum;
    end

    assign p = p_q;
  end else begin : g_latn
    logic [PW-1:0] pp_q  [WIDTH];
    logic [PW-1:0] sum;
    logic [PW-1:0] stg_q [LAT-1];

    // Partial-product register stage.
    // NOTE: the datapath pipeline is cleared on reset only so no X ever reaches HI/LO in simulation; its contents are otherwise don't-care.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < WIDTH; i++) pp_q[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) pp_q[i] <= pp_d[i];
      end
    end

    // Adder tree over the registered partial products.
    always_comb begin
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
        sum = sum + pp_q[i];
      end
    end

    // Sum register followed by delay stages up to the configured latency.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < LAT - 1; i++) stg_q[i] <= '0;
      end else begin
        stg_q[0] <= sum;
        for (int i = 1; i < LAT - 1; i++) stg_q[i] <= stg_q[i-1];
      end
    end

    assign p = stg_q[LAT-2];
  end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// MULT/MULTU sequencer: feeds operand magnitudes to the multiplier core, waits
// out its latency, applies the sign fix-up and commits to HI/LO. Also serves
// MTHI/MTLO writes while idle. WIDTH must equal MUL_WIDTH, which sizes the
// sign helpers in mul_pkg.
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int LAT   = MUL_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             start_ready,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(LAT + 1);

  mul_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_neg_q, sign_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] core_p;
  logic [2*WIDTH-1:0] product;

  // The core loads every cycle; only the value present at the accepting edge
  // is ever committed, as the counter tracks exactly that one.
  assign a_mag   = mul_mag(a, op_signed);
  assign b_mag   = mul_mag(b, op_signed);
  assign product = sign_neg_q ? mul_neg(core_p) : core_p;

  mul_core_u #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .a     (a_mag),
    .b     (b_mag),
    .p     (core_p)
  );

  // Next state: flush beats start, start beats MTHI/MTLO.
  // NOTE: every signal written here gets its default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sign_neg_d = sign_neg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (start) begin
          state_d    = RUN;
          cnt_d      = CNT_W'(LAT);
          sign_neg_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else begin
          if (mthi_en) hi_d = mt_data;
          if (mtlo_en) lo_d = mt_data;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          {hi_d, lo_d} = product;
          state_d      = IDLE;
          cnt_d        = '0;
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and architectural register update.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sign_neg_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sign_neg_q <= sign_neg_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with LAT=2, WIDTH=32.
module tb_mul_hilo_ctrl;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic        start_ready;
  logic        op_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        mthi_en;
  logic        mtlo_en;
  logic [31:0] mt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [8];

  mul_hilo_ctrl #(
    .WIDTH (32),
    .LAT   (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .start_ready (start_ready),
    .op_signed   (op_signed),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .mthi_en     (mthi_en),
    .mtlo_en     (mtlo_en),
    .mt_data     (mt_data),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply from IDLE and follow it to its done pulse.
  task automatic run_mul(input string name, input logic sgn, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    op_signed = sgn;
    a         = va;
    b         = vb;
    start     = 1'b1;
    step();
    start = 1'b0;
    check({name, " busy after accept"}, 64'(busy), 64'd1);
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({name, " busy cycles"}, 64'(n), 64'(LAT));
    check({name, " hi/lo"}, {hi, lo}, {ehi, elo});
    check({name, " done"}, 64'(done), 64'd1);
    step();
    check({name, " done width"}, 64'(done), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0004, 32'hFFFF_FFF1};

    reset     = 1'b0;
    start     = 1'b0;
    op_signed = 1'b0;
    a         = '0;
    b         = '0;
    flush     = 1'b0;
    mthi_en   = 1'b0;
    mtlo_en   = 1'b0;
    mt_data   = '0;

    // Reset state
    #12;
    check("reset hi/lo", {hi, lo}, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset start_ready", 64'(start_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // MTHI alone, then MTHI+MTLO together
    mthi_en = 1'b1;
    mt_data = 32'h0000_ABCD;
    step();
    mthi_en = 1'b0;
    check("mthi hi", 64'(hi), 64'h0000_ABCD);
    check("mthi lo untouched", 64'(lo), 64'd0);
    mthi_en = 1'b1;
    mtlo_en = 1'b1;
    mt_data = 32'h0000_0077;
    step();
    mthi_en = 1'b0;
    mtlo_en = 1'b0;
    check("mthi+mtlo", {hi, lo}, {32'h77, 32'h77});

    // Table-driven multiplies
    for (int i = 0; i < 8; i++) begin
      run_mul($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
    end

    // Back-to-back: start held through busy, new op accepted in the done cycle
    op_signed = 1'b0;
    a         = 32'd7;
    b         = 32'd6;
    start     = 1'b1;
    step();
    check("b2b first busy", 64'(busy), 64'd1);
    check("b2b not ready", 64'(start_ready), 64'd0);
    step();
    check("b2b held start ignored", 64'(busy), 64'd1);
    step();
    check("b2b first result", {hi, lo}, 64'd42);
    check("b2b first done", 64'(done), 64'd1);
    check("b2b ready in done cycle", 64'(start_ready), 64'd1);
    op_signed = 1'b1;
    a         = 32'hFFFF_FFFF;
    b         = 32'hFFFF_FFFF;
    step();
    start = 1'b0;
    check("b2b second accepted", 64'(busy), 64'd1);
    check("b2b done drops", 64'(done), 64'd0);
    step();
    step();
    check("b2b second result", {hi, lo}, 64'd1);
    check("b2b second done", 64'(done), 64'd1);

    // Flush in RUN keeps HI/LO and suppresses done
    mthi_en = 1'b1;
    mt_data = 32'h11;
    step();
    mthi_en = 1'b0;
    mtlo_en = 1'b1;
    mt_data = 32'h22;
    step();
    mtlo_en   = 1'b0;
    op_signed = 1'b0;
    a         = 32'd3;
    b         = 32'd4;
    start     = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b1;
    check("flush busy before", 64'(busy), 64'd1);
    step();
    flush = 1'b0;
    check("flush busy after", 64'(busy), 64'd0);
    check("flush start_ready", 64'(start_ready), 64'd1);
    check("flush hi/lo kept", {hi, lo}, {32'h11, 32'h22});
    step();
    check("flush no done", 64'(done), 64'd0);
    step();
    check("flush hi/lo still kept", {hi, lo}, {32'h11, 32'h22});
    check("flush no late done", 64'(done), 64'd0);

    // Flush together with start in IDLE: start ignored
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    check("idle flush+start busy", 64'(busy), 64'd0);
    step();
    step();
    check("idle flush+start hi/lo", {hi, lo}, {32'h11, 32'h22});

    // MTLO while busy is dropped
    a     = 32'd2;
    b     = 32'd2;
    start = 1'b1;
    step();
    start   = 1'b0;
    mtlo_en = 1'b1;
    mt_data = 32'h5555;
    step();
    mtlo_en = 1'b0;
    check("mtlo while busy lo", 64'(lo), 64'h22);
    check("mtlo while busy still busy", 64'(busy), 64'd1);
    step();
    check("mtlo while busy result", {hi, lo}, 64'd4);
    check("mtlo while busy done", 64'(done), 64'd1);

    // Start and MTHI together: multiply wins, MTHI dropped
    mthi_en = 1'b1;
    mt_data = 32'h33;
    step();
    check("mthi set 0x33", 64'(hi), 64'h33);
    mt_data = 32'h9999;
    a       = 32'd5;
    b       = 32'd5;
    start   = 1'b1;
    step();
    start   = 1'b0;
    mthi_en = 1'b0;
    check("start+mthi accepted", 64'(busy), 64'd1);
    check("start+mthi hi kept", 64'(hi), 64'h33);
    step();
    step();
    check("start+mthi result", {hi, lo}, 64'd25);

    // Async reset mid-RUN
    a     = 32'hFFFF_FFFF;
    b     = 32'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async reset hi/lo", {hi, lo}, 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    check("async reset start_ready", 64'(start_ready), 64'd1);
    step();
    reset = 1'b1;
    step();
    step();
    check("after reset no commit", {hi, lo}, 64'd0);
    check("after reset no done", 64'(done), 64'd0);
    run_mul("post-reset", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
